eth_rx_ctrl: RTL and testbench
==============================

# eth_rx_ctrl

RMII receive control block: the receive-side counterpart of the Ethernet transmit control FSM. It samples the 2-bit RMII receive bus and finds the preamble and SFD. It assembles dibits into bytes, streams them downstream, counts frame bytes and checks FCS and length. At end of frame it reports one good/bad status pulse. It sits between the RMII PHY pins and the receive data FIFO/parser, in the 50 MHz RMII reference clock domain.

## Interface
Parameters:
- pMIN_FRAME_BYTES, 64: minimum legal frame length after SFD, including FCS.
- pMAX_FRAME_BYTES, 1518: maximum legal frame length after SFD, including FCS.
- pMIN_PRE_DIBITS, 8: minimum count of consecutive 01 dibits before the SFD dibit.

Ports:
- Clk  in  1  50 MHz RMII reference clock.
- Rst  in  1  reset, synchronous, active-high.
- Crs_Dv  in  1  RMII carrier sense / data valid.
- Rxd  in  2  RMII receive dibit, LSB-first.
- Rx_Byte  out  8  assembled byte.
- Rx_Byte_Vld  out  1  one-cycle strobe; Rx_Byte is valid.
- Rx_SOP  out  1  high with the first Rx_Byte_Vld of a frame.
- Rx_EOP  out  1  one-cycle end-of-frame pulse.
- Frame_Good  out  1  coincident with Rx_EOP; frame passed all checks.
- Frame_Bad  out  1  coincident with Rx_EOP; frame failed a check.
- Byte_Cnt  out  11  bytes received since SFD; saturates at 2047.
- Rx_Ctrl_FSM_State  out  eth_rx_ctrl_state_t  current state.

## Operation
- Reset: all outputs 0, Byte_Cnt 0, state IDLE. Reset aborts any frame mid-operation with no status pulse.
- IDLE (0):
  - Crs_Dv=1 and Rxd=01 -> PREAMBLE with the preamble count set to 1.
  - Crs_Dv=1 and Rxd=00 -> remain in IDLE.
  - Clears the dibit counter and Byte_Cnt.
- PREAMBLE (1):
  - Rxd=01: preamble count increments, saturating.
  - Rxd=11 with count ≥ pMIN_PRE_DIBITS -> DATA.
  - Rxd=11 with count below the minimum -> DISCARD.
  - Rxd=00 or 10, or Crs_Dv=0 -> IDLE.
- DATA (2):
  - Each Crs_Dv=1 cycle shifts Rxd into bits [2k+1:2k], k = dibit index 0..3.
  - On k=3 the byte is complete: Byte_Cnt increments and the byte is fed to the CRC.
  - Crs_Dv=0 -> CHECK.
  - If Byte_Cnt exceeds pMAX_FRAME_BYTES: pulse Rx_EOP and Frame_Bad, then -> DISCARD.
- CHECK (3), one cycle:
  - Pulse Rx_EOP, then -> IDLE.
  - Frame_Good only if all hold: dibit index = 0 (aligned), Byte_Cnt ≥ pMIN_FRAME_BYTES, and CRC register = 32'hDEBB20E3.
  - Otherwise Frame_Bad.
- DISCARD (4): no outputs; -> IDLE when Crs_Dv=0.
- Status rule: exactly one of Frame_Good/Frame_Bad per Rx_EOP, never both.
- Flow control: none. Bytes arrive at most once every 4 cycles, and the downstream block must accept every strobe.
- CRC: CRC-32, reflected polynomial 32'hEDB88320, initialised to 32'hFFFFFFFF when entering DATA. It is updated per byte over all bytes after the SFD, including the FCS.

## Timing
- Rx_Byte/Rx_Byte_Vld are registered, asserted the cycle after the 4th dibit is sampled.
- The CRC register is updated the cycle after byte completion and is stable before CHECK.
- Rx_EOP/status fire 2 cycles after the first Crs_Dv=0 sample: 1 cycle to enter CHECK, 1 registered cycle.
- Minimum inter-strobe spacing is 4 cycles.

## Configuration
- ETH_RX_FCS_STRIP_EN defined:
  - A 4-byte delay line withholds the last 4 bytes, so FCS bytes are never strobed.
  - Byte k is output when byte k+4 completes, and Rx_SOP marks the first output byte.
  - Byte_Cnt, the length checks and the CRC still include the FCS.
- ETH_RX_FCS_STRIP_EN undefined: every byte, including the FCS, is strobed at its completion.

## Structure
- eth_rx_pkg holds:
  - eth_rx_ctrl_state_t {IDLE, PREAMBLE, DATA, CHECK, DISCARD};
  - pPRE_DIBIT=2'b01, pSFD_DIBIT=2'b11;
  - pCRC_POLY=32'hEDB88320, pCRC_INIT=32'hFFFFFFFF, pCRC_RESIDUE=32'hDEBB20E3.
- Sub-module eth_rx_crc: byte-wide CRC-32 with inputs Clk, Rst, Init, En, Data[7:0] and output Crc[31:0].

## Test plan
- 64-byte frame with valid FCS, preceded by 7×0x55 + 0xD5 -> 64 strobes (60 with strip), Rx_SOP on the first, Byte_Cnt=64, Rx_EOP+Frame_Good once.
- Same frame with one payload bit flipped -> Rx_EOP+Frame_Bad, no Frame_Good.
- 63-byte frame with valid FCS -> Frame_Bad (runt). 1519-byte frame -> Frame_Bad at byte 1519, then DISCARD with no further strobes.
- Crs_Dv dropped after 2 dibits of byte 70 -> Frame_Bad (misaligned); 69 strobes.
- SFD after only 4 preamble dibits -> DISCARD, no strobes or status; the following good frame -> Frame_Good.
- Rst pulsed mid-DATA -> all outputs 0 next cycle, state IDLE, no Rx_EOP; the next frame -> Frame_Good.

Source files
------------

// File: rtl/eth_rx_pkg.sv
// rtl/eth_rx_pkg.sv - shared types, constants and CRC-32 byte step for the RMII receive path
package eth_rx_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        DATA     = 3'd2,
        CHECK    = 3'd3,
        DISCARD  = 3'd4
    } eth_rx_ctrl_state_t;

    localparam logic [1:0]  pPRE_DIBIT   = 2'b01;
    localparam logic [1:0]  pSFD_DIBIT   = 2'b11;
    localparam logic [31:0] pCRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] pCRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] pCRC_RESIDUE = 32'hDEBB20E3;

    // Reflected CRC-32, data consumed LSB first as it arrives on the wire
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ pCRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_rx_crc.sv
// rtl/eth_rx_crc.sv - byte-wide CRC-32 register with synchronous init
module eth_rx_crc
    import eth_rx_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Init,
    input  logic        En,
    input  logic [7:0]  Data,
    output logic [31:0] Crc
);

    always_ff @(posedge Clk) begin
        if (Rst || Init) begin
            Crc <= pCRC_INIT;
        end else if (En) begin
            Crc <= crc32_byte(Crc, Data);
        end
    end

endmodule

// File: rtl/eth_rx_ctrl.sv
// rtl/eth_rx_ctrl.sv - RMII receive control: preamble/SFD hunt, byte assembly, FCS and length check
// ETH_RX_FCS_STRIP_EN withholds the last four bytes of each frame so the FCS is never strobed.
module eth_rx_ctrl
    import eth_rx_pkg::*;
#(
    parameter int pMIN_FRAME_BYTES = 64,
    parameter int pMAX_FRAME_BYTES = 1518,
    parameter int pMIN_PRE_DIBITS  = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Crs_Dv,
    input  logic [1:0]         Rxd,
    output logic [7:0]         Rx_Byte,
    output logic               Rx_Byte_Vld,
    output logic               Rx_SOP,
    output logic               Rx_EOP,
    output logic               Frame_Good,
    output logic               Frame_Bad,
    output logic [10:0]        Byte_Cnt,
    output eth_rx_ctrl_state_t Rx_Ctrl_FSM_State
);

    localparam int              PRE_W     = $clog2(pMIN_PRE_DIBITS + 1);
    localparam logic [PRE_W-1:0] PRE_MIN   = PRE_W'(pMIN_PRE_DIBITS);
    localparam logic [10:0]     MIN_BYTES = 11'(pMIN_FRAME_BYTES);
    localparam logic [10:0]     MAX_BYTES = 11'(pMAX_FRAME_BYTES);

    eth_rx_ctrl_state_t state, state_nxt;
    logic [PRE_W-1:0]   pre_cnt;
    logic [1:0]         dibit_idx;
    logic [5:0]         shift_byte;
    logic [7:0]         byte_q;
    logic               byte_done_q;
    logic [31:0]        crc;
    logic               crc_init, eop_set, good_set, bad_set, dibit_take;
    logic               byte_complete;
    logic [7:0]         new_byte;
`ifdef ETH_RX_FCS_STRIP_EN
    logic [3:0][7:0]    dly;
`endif

    assign Rx_Ctrl_FSM_State = state;
    assign byte_complete     = dibit_take && (dibit_idx == 2'd3);
    assign new_byte          = {Rxd, shift_byte};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        crc_init   = 1'b0;
        eop_set    = 1'b0;
        good_set   = 1'b0;
        bad_set    = 1'b0;
        dibit_take = 1'b0;
        case (state)
            IDLE: begin
                if (Crs_Dv && Rxd == pPRE_DIBIT) state_nxt = PREAMBLE;
            end
            PREAMBLE: begin
                if (!Crs_Dv) begin
                    state_nxt = IDLE;
                end else if (Rxd == pSFD_DIBIT) begin
                    if (pre_cnt >= PRE_MIN) begin
                        state_nxt = DATA;
                        crc_init  = 1'b1;
                    end else begin
                        state_nxt = DISCARD;
                    end
                end else if (Rxd != pPRE_DIBIT) begin
                    state_nxt = IDLE;
                end
            end
            DATA: begin
                // Oversize wins over end of carrier so the frame reports exactly once
                if (Byte_Cnt > MAX_BYTES) begin
                    eop_set   = 1'b1;
                    bad_set   = 1'b1;
                    state_nxt = DISCARD;
                end else if (!Crs_Dv) begin
                    state_nxt = CHECK;
                end else begin
                    dibit_take = 1'b1;
                end
            end
            CHECK: begin
                eop_set   = 1'b1;
                state_nxt = IDLE;
                if (dibit_idx == 2'd0 && Byte_Cnt >= MIN_BYTES && crc == pCRC_RESIDUE) begin
                    good_set = 1'b1;
                end else begin
                    bad_set = 1'b1;
                end
            end
            DISCARD: begin
                if (!Crs_Dv) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Rx_Byte     <= '0;
            Rx_Byte_Vld <= 1'b0;
            Rx_SOP      <= 1'b0;
            Rx_EOP      <= 1'b0;
            Frame_Good  <= 1'b0;
            Frame_Bad   <= 1'b0;
            Byte_Cnt    <= '0;
            pre_cnt     <= '0;
            dibit_idx   <= '0;
            shift_byte  <= '0;
            byte_q      <= '0;
            byte_done_q <= 1'b0;
`ifdef ETH_RX_FCS_STRIP_EN
            dly         <= '0;
`endif
        end else begin
            Rx_Byte_Vld <= 1'b0;
            Rx_SOP      <= 1'b0;
            Rx_EOP      <= eop_set;
            Frame_Good  <= good_set;
            Frame_Bad   <= bad_set;
            byte_done_q <= byte_complete;

            if (state == IDLE) begin
                pre_cnt   <= PRE_W'(1);
                dibit_idx <= '0;
                Byte_Cnt  <= '0;
            end else if (state == PREAMBLE && Crs_Dv && Rxd == pPRE_DIBIT && pre_cnt != PRE_MIN) begin
                pre_cnt <= pre_cnt + 1'b1;
            end

            if (dibit_take) begin
                dibit_idx  <= dibit_idx + 2'd1;
                shift_byte <= {Rxd, shift_byte[5:2]};
            end

            if (byte_complete) begin
                byte_q <= new_byte;
                if (Byte_Cnt != 11'h7FF) Byte_Cnt <= Byte_Cnt + 11'd1;
`ifdef ETH_RX_FCS_STRIP_EN
                // A byte only leaves once four newer bytes prove it is not FCS
                dly <= {dly[2:0], new_byte};
                if (Byte_Cnt >= 11'd4) begin
                    Rx_Byte     <= dly[3];
                    Rx_Byte_Vld <= 1'b1;
                    Rx_SOP      <= (Byte_Cnt == 11'd4);
                end
`else
                Rx_Byte     <= new_byte;
                Rx_Byte_Vld <= 1'b1;
                Rx_SOP      <= (Byte_Cnt == 11'd0);
`endif
            end
        end
    end

    eth_rx_crc u_crc (
        .Clk  (Clk),
        .Rst  (Rst),
        .Init (crc_init),
        .En   (byte_done_q),
        .Data (byte_q),
        .Crc  (crc)
    );

endmodule

// File: tb/tb_eth_rx_ctrl.sv
// tb/tb_eth_rx_ctrl.sv - randomized self-checking bench for eth_rx_ctrl against a frame-level model
module tb_eth_rx_ctrl;
    import eth_rx_pkg::*;

`ifdef ETH_RX_FCS_STRIP_EN
    localparam bit STRIP = 1'b1;
`else
    localparam bit STRIP = 1'b0;
`endif
    localparam int MIN_B = 64;
    localparam int MAX_B = 1518;

    logic               Clk = 1'b0;
    logic               Rst = 1'b1;
    logic               Crs_Dv = 1'b0;
    logic [1:0]         Rxd = 2'b00;
    logic [7:0]         Rx_Byte;
    logic               Rx_Byte_Vld, Rx_SOP, Rx_EOP, Frame_Good, Frame_Bad;
    logic [10:0]        Byte_Cnt;
    eth_rx_ctrl_state_t Rx_Ctrl_FSM_State;

    eth_rx_ctrl dut (
        .Clk               (Clk),
        .Rst               (Rst),
        .Crs_Dv            (Crs_Dv),
        .Rxd               (Rxd),
        .Rx_Byte           (Rx_Byte),
        .Rx_Byte_Vld       (Rx_Byte_Vld),
        .Rx_SOP            (Rx_SOP),
        .Rx_EOP            (Rx_EOP),
        .Frame_Good        (Frame_Good),
        .Frame_Bad         (Frame_Bad),
        .Byte_Cnt          (Byte_Cnt),
        .Rx_Ctrl_FSM_State (Rx_Ctrl_FSM_State)
    );

    always #10 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0]  got_q[$];
    logic [7:0]  frame_q[$];
    int          sop_cnt, eop_cnt, good_cnt, bad_cnt, both_cnt;
    logic        first_sop;
    logic [10:0] eop_bytecnt;

    always @(negedge Clk) begin
        if (Rx_Byte_Vld) begin
            if (got_q.size() == 0) first_sop = Rx_SOP;
            got_q.push_back(Rx_Byte);
        end
        if (Rx_SOP) sop_cnt++;
        if (Rx_EOP) begin
            eop_cnt++;
            eop_bytecnt = Byte_Cnt;
            if (Frame_Good) good_cnt++;
            if (Frame_Bad) bad_cnt++;
        end
        if (Frame_Good && Frame_Bad) both_cnt++;
    end

    task automatic clear_mon();
        got_q.delete();
        sop_cnt = 0; eop_cnt = 0; good_cnt = 0; bad_cnt = 0; both_cnt = 0;
        first_sop = 1'b0; eop_bytecnt = '0;
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Random payload of n-4 bytes followed by its FCS, least significant byte first
    task automatic build_frame(input int n);
        logic [31:0] c;
        logic [31:0] fcs;
        frame_q.delete();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n - 4; i++) begin
            frame_q.push_back(8'($urandom_range(0, 255)));
            c = crc_step(c, frame_q[i]);
        end
        fcs = ~c;
        for (int i = 0; i < 4; i++) frame_q.push_back(fcs[8*i +: 8]);
    endtask

    task automatic put(input logic dv, input logic [1:0] d);
        @(posedge Clk);
        #1;
        Crs_Dv = dv;
        Rxd    = d;
    endtask

    task automatic send(input int n_pre, input int n_bytes, input int tail, input bit close);
        logic [7:0] v;
        for (int i = 0; i < n_pre; i++) put(1'b1, 2'b01);
        put(1'b1, 2'b11);
        for (int b = 0; b < n_bytes; b++) begin
            v = frame_q[b];
            for (int k = 0; k < 4; k++) put(1'b1, v[2*k +: 2]);
        end
        for (int t = 0; t < tail; t++) put(1'b1, 2'($urandom_range(0, 3)));
        if (close) begin
            put(1'b0, 2'b00);
            repeat (12) @(posedge Clk);
            #1;
        end
    endtask

    task automatic evaluate(input string name, input int n_bytes, input int tail, input bit sfd_ok);
        int          completed, exp_strobes, mism, lim;
        bit          fcs_ok, exp_good;
        logic [31:0] c, trail;
        completed   = sfd_ok ? ((n_bytes > MAX_B + 1) ? MAX_B + 1 : n_bytes) : 0;
        exp_strobes = STRIP ? ((completed > 4) ? completed - 4 : 0) : completed;
        fcs_ok = 1'b0;
        if (n_bytes >= 4) begin
            c = 32'hFFFFFFFF;
            for (int i = 0; i < n_bytes - 4; i++) c = crc_step(c, frame_q[i]);
            trail = {frame_q[n_bytes-1], frame_q[n_bytes-2], frame_q[n_bytes-3], frame_q[n_bytes-4]};
            fcs_ok = (~c == trail);
        end
        exp_good = sfd_ok && tail == 0 && n_bytes >= MIN_B && n_bytes <= MAX_B && fcs_ok;
        check_eq({name, ".strobes"}, got_q.size(), exp_strobes);
        mism = 0;
        lim  = (got_q.size() < exp_strobes) ? got_q.size() : exp_strobes;
        for (int i = 0; i < lim; i++) if (got_q[i] !== frame_q[i]) mism++;
        check_eq({name, ".data"}, mism, 0);
        check_eq({name, ".sop_cnt"}, sop_cnt, (exp_strobes > 0) ? 1 : 0);
        check_eq({name, ".sop_first"}, first_sop, (exp_strobes > 0) ? 1 : 0);
        check_eq({name, ".eop"}, eop_cnt, sfd_ok ? 1 : 0);
        check_eq({name, ".good"}, good_cnt, exp_good ? 1 : 0);
        check_eq({name, ".bad"}, bad_cnt, (sfd_ok && !exp_good) ? 1 : 0);
        check_eq({name, ".excl"}, both_cnt, 0);
        if (sfd_ok) check_eq({name, ".bytecnt"}, eop_bytecnt, completed);
        clear_mon();
    endtask

    task automatic run_frame(input string name, input int n_pre, input int n_bytes, input int tail);
        send(n_pre, n_bytes, tail, 1'b1);
        evaluate(name, n_bytes, tail, n_pre >= 8);
    endtask

    initial begin
        int n, tail, pre, idx;
        clear_mon();
        repeat (3) @(posedge Clk);
        #1;
        check_eq("reset.outs", {Rx_Byte, Rx_Byte_Vld, Rx_SOP, Rx_EOP, Frame_Good, Frame_Bad, Byte_Cnt}, 0);
        check_eq("reset.state", Rx_Ctrl_FSM_State, IDLE);
        Rst = 1'b0;
        repeat (2) @(posedge Clk);

        build_frame(64);
        run_frame("good64", 31, 64, 0);

        idx = $urandom_range(0, 59);
        frame_q[idx] = frame_q[idx] ^ 8'(1 << $urandom_range(0, 7));
        run_frame("flip64", 31, 64, 0);

        build_frame(63);
        run_frame("runt63", 31, 63, 0);

        build_frame(1530);
        run_frame("oversize", 31, 1530, 0);

        build_frame(72);
        run_frame("misalign", 31, 69, 2);

        build_frame(64);
        send(4, 64, 0, 1'b1);
        evaluate("shortpre", 64, 0, 1'b0);
        send(7, 64, 0, 1'b1);
        evaluate("pre7", 64, 0, 1'b0);
        run_frame("pre8", 8, 64, 0);

        build_frame(64);
        send(31, 20, 0, 1'b0);
        check_eq("rst.mid_state", Rx_Ctrl_FSM_State, DATA);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        Crs_Dv = 1'b0;
        @(posedge Clk);
        #1;
        check_eq("rst.outs", {Rx_Byte, Rx_Byte_Vld, Rx_SOP, Rx_EOP, Frame_Good, Frame_Bad, Byte_Cnt}, 0);
        check_eq("rst.state", Rx_Ctrl_FSM_State, IDLE);
        Rst = 1'b0;
        repeat (12) @(posedge Clk);
        #1;
        check_eq("rst.no_eop", eop_cnt, 0);
        clear_mon();
        build_frame(64);
        run_frame("after_rst", 31, 64, 0);

        for (int f = 0; f < 8; f++) begin
            n    = $urandom_range(60, 130);
            pre  = $urandom_range(8, 31);
            tail = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
            build_frame(n);
            if ($urandom_range(0, 2) == 0) begin
                idx = $urandom_range(0, n - 1);
                frame_q[idx] = frame_q[idx] ^ 8'(1 << $urandom_range(0, 7));
            end
            run_frame($sformatf("rand%0d", f), pre, n, tail);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
